vram_arbiter: RTL

Single-port video-memory arbiter that shares one frame-buffer RAM port among three requesters: VGA line prefetch, sprite blitter and the Nios II CPU. It sits between the VGA controller / blitter / CPU Avalon-MM bridge and the on-chip frame-buffer RAM. It issues at most one access per cycle and returns tagged read data after a fixed latency. The VGA requester has priority, bounded by a starvation counter; the blitter and CPU share the remaining slots round-robin.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_tag_pipe.sv | 45 ++++
 rtl/vram_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_pkg
//   Shared types and default widths for the video-memory arbiter slice.
//   req_id_t tags each memory access with the requester that issued it, so
//   read data can be routed back; REQ_NONE marks writes and idle slots.
package vram_pkg;

  localparam int VRAM_AW = 19;
  localparam int VRAM_DW = 16;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_VGA,
    REQ_BLT,
    REQ_CPU
  } req_id_t;

endpackage

// File: rtl/vram_tag_pipe.sv
// vram_tag_pipe
//   Shift register of requester tags, RD_LAT stages deep. A tag pushed in
//   alongside a RAM access comes out in the same cycle as that access's
//   read data, so the top can route mem_rdata to the right requester.
//   Ports:
//     clk     - rising-edge clock
//     rst_n   - asynchronous active-low clear (all stages become REQ_NONE)
//     tag_in  - tag of the access currently on the RAM port
//     tag_out - tag of the access whose read data is on mem_rdata now
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  req_id_t tag_in,
  output req_id_t tag_out
);

  req_id_t stage_q [RD_LAT];
  req_id_t stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Clearing the pipe on reset drops every in-flight read, so nothing
  // accepted before reset can ever produce an rvalid afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= REQ_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port frame-buffer RAM among VGA prefetch, the sprite
//   blitter and the CPU. One access is granted per cycle; VGA has priority
//   but a starvation counter forces a blitter/CPU slot after STARVE_MAX
//   consecutive VGA wins. Blitter and CPU share slots round-robin.
//   Ports:
//     clk_clk, reset_reset_n           - clock, async active-low reset
//     vga_req/vga_addr, vga_gnt        - VGA read port (read only)
//     blt_req/we/addr/wdata, blt_gnt   - blitter port
//     cpu_req/we/addr/wdata, cpu_gnt   - CPU port
//     vga/blt/cpu_rvalid, rdata        - tagged read return, RD_LAT+2 after grant
//     mem_en/we/addr/wdata, mem_rdata  - RAM port (registered one cycle after grant)
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW         = VRAM_AW,
  parameter int DW         = VRAM_DW,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  input  logic          blt_req,
  input  logic          blt_we,
  input  logic [AW-1:0] blt_addr,
  input  logic [DW-1:0] blt_wdata,
  output logic          blt_gnt,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          vga_rvalid,
  output logic          blt_rvalid,
  output logic          cpu_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);

  req_id_t        rr_last_q, rr_last_d;
  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic           mem_en_q, mem_en_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  req_id_t        mem_tag_q, mem_tag_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           vga_rvalid_q, vga_rvalid_d;
  logic           blt_rvalid_q, blt_rvalid_d;
  logic           cpu_rvalid_q, cpu_rvalid_d;

  req_id_t        rr_pick;
  req_id_t        winner;
  req_id_t        ret_tag;
  logic           lower_req;

  // Grant selection. Grants are forced low while reset is asserted so that
  // every output reads 0 during reset, even with requests held high.
  always_comb begin
    lower_req = blt_req | cpu_req;

    rr_pick = REQ_NONE;
    if (blt_req && cpu_req) begin
      rr_pick = (rr_last_q == REQ_BLT) ? REQ_CPU : REQ_BLT;
    end else if (blt_req) begin
      rr_pick = REQ_BLT;
    end else if (cpu_req) begin
      rr_pick = REQ_CPU;
    end

    winner = REQ_NONE;
    if (!reset_reset_n) begin
      winner = REQ_NONE;
    end else if ((starve_cnt_q == STARVE_TOP) && lower_req) begin
      winner = rr_pick;
    end else if (vga_req) begin
      winner = REQ_VGA;
    end else begin
      winner = rr_pick;
    end

    vga_gnt = (winner == REQ_VGA);
    blt_gnt = (winner == REQ_BLT);
    cpu_gnt = (winner == REQ_CPU);
  end

  // Arbiter state: the counter only runs while a blitter/CPU request is
  // actually waiting behind VGA, so a dropped request clears it.
  always_comb begin
    rr_last_d    = rr_last_q;
    starve_cnt_d = starve_cnt_q;
    if (blt_gnt || cpu_gnt) begin
      rr_last_d = winner;
    end
    if (blt_gnt || cpu_gnt || !lower_req) begin
      starve_cnt_d = '0;
    end else if (vga_gnt && (starve_cnt_q != STARVE_TOP)) begin
      starve_cnt_d = starve_cnt_q + SCW'(1);
    end
  end

  // RAM command stage. Address/data hold their last value in idle cycles to
  // avoid needless toggling on the RAM pins; only mem_en/mem_we matter then.
  always_comb begin
    mem_en_d    = (winner != REQ_NONE);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_tag_d   = REQ_NONE;
    unique case (winner)
      REQ_VGA: begin
        mem_addr_d = vga_addr;
        mem_tag_d  = REQ_VGA;
      end
      REQ_BLT: begin
        mem_we_d    = blt_we;
        mem_addr_d  = blt_addr;
        mem_wdata_d = blt_wdata;
        mem_tag_d   = blt_we ? REQ_NONE : REQ_BLT;
      end
      REQ_CPU: begin
        mem_we_d    = cpu_we;
        mem_addr_d  = cpu_addr;
        mem_wdata_d = cpu_wdata;
        mem_tag_d   = cpu_we ? REQ_NONE : REQ_CPU;
      end
      default: begin
        mem_tag_d = REQ_NONE;
      end
    endcase
  end

  // The tag enters the pipe together with mem_en, so it leaves exactly when
  // the RAM presents that access's data.
  vram_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .tag_in (mem_tag_q),
    .tag_out(ret_tag)
  );

  // Read return: capture RAM data and pulse the matching rvalid.
  always_comb begin
    rdata_d      = (ret_tag != REQ_NONE) ? mem_rdata : rdata_q;
    vga_rvalid_d = (ret_tag == REQ_VGA);
    blt_rvalid_d = (ret_tag == REQ_BLT);
    cpu_rvalid_d = (ret_tag == REQ_CPU);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rr_last_q    <= REQ_CPU;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_tag_q    <= REQ_NONE;
      rdata_q      <= '0;
      vga_rvalid_q <= 1'b0;
      blt_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      rr_last_q    <= rr_last_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_tag_q    <= mem_tag_d;
      rdata_q      <= rdata_d;
      vga_rvalid_q <= vga_rvalid_d;
      blt_rvalid_q <= blt_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata      = rdata_q;
  assign vga_rvalid = vga_rvalid_q;
  assign blt_rvalid = blt_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;

endmodule
